stream_demux_1_4: RTL

Registered 1-to-4 stream demultiplexer: accepts one valid/ready input stream carrying a W-bit word plus a 2-bit destination select, and delivers each word to exactly one of four valid/ready output channels. It is the distribution counterpart of the 4-to-1 selection tree. It sits between a single producer and four independent consumers. Each output channel owns a small holding buffer, so one stalled consumer blocks only words addressed to it.

---
 rtl/stream_demux_1_4_if.sv | 14 +
 rtl/stream_demux_1_4.sv | 72 +++++++
 2 files changed

// File: rtl/stream_demux_1_4_if.sv
// stream_demux_1_4_if: producer-side stream plus four consumer channels of the 1-to-4 demux.
interface stream_demux_1_4_if #(parameter int W = 4) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
  modport master (output in_valid, in_data, in_sel, out_ready,
                  input  in_ready, out_valid, out_d0, out_d1, out_d2, out_d3);
  modport slave  (input  in_valid, in_data, in_sel, out_ready,
                  output in_ready, out_valid, out_d0, out_d1, out_d2, out_d3);
endinterface

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: registered 1-to-4 valid/ready demux with a holding buffer per channel.
// STREAM_DEMUX_SKID_EN selects 2-entry FIFOs whose in_ready depends on registered state only.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input logic clk,
  input logic rst_n,
  stream_demux_1_4_if.slave bus
);
  logic [3:0]   push, pop, vld;
  logic [W-1:0] m0_q [4];
  logic [W-1:0] m0_d [4];
  assign pop = vld & bus.out_ready;
  assign push = {4{bus.in_valid & bus.in_ready}} & (4'b0001 << bus.in_sel);
  assign bus.out_valid = vld;
  assign bus.out_d0 = m0_q[0];
  assign bus.out_d1 = m0_q[1];
  assign bus.out_d2 = m0_q[2];
  assign bus.out_d3 = m0_q[3];
`ifdef STREAM_DEMUX_SKID_EN
  logic [1:0]   cnt_q [4];
  logic [1:0]   cnt_d [4];
  logic [W-1:0] m1_q [4];
  logic [W-1:0] m1_d [4];
  for (genvar i = 0; i < 4; i++) begin : g_vld
    assign vld[i] = cnt_q[i] != 2'd0;
  end
  assign bus.in_ready = cnt_q[bus.in_sel] != 2'd2;
  // m0 is the head; a pop shifts m1 forward, a push lands in the first free slot after the pop
  always_comb begin
    cnt_d = cnt_q;
    m0_d = m0_q;
    m1_d = m1_q;
    for (int c = 0; c < 4; c++) begin
      if (pop[c]) m0_d[c] = m1_q[c];
      if (push[c] && (cnt_q[c] == 2'd0 || (cnt_q[c] == 2'd1 && pop[c]))) m0_d[c] = bus.in_data;
      else if (push[c]) m1_d[c] = bus.in_data;
      cnt_d[c] = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
      m0_q <= '{default: '0};
      m1_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      m0_q <= m0_d;
      m1_q <= m1_d;
    end
  end
`else
  logic [3:0] v_q, v_d;
  assign vld = v_q;
  assign bus.in_ready = !v_q[bus.in_sel] || bus.out_ready[bus.in_sel];
  always_comb begin
    v_d = (v_q & ~pop) | push;
    m0_d = m0_q;
    for (int c = 0; c < 4; c++)
      if (push[c]) m0_d[c] = bus.in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      m0_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      m0_q <= m0_d;
    end
  end
`endif
endmodule
